dm_port_arbiter: RTL
====================

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4: number of consecutive cycles r1 may be denied before it is boosted (range 1..15).
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports r0_req/r1_req  input  1  requester n presents a transaction (r0 = CPU M-stage, r1 = loader/debug).
REQ-005 SHALL have ports rN_addr  input  32  byte address; rN_wdata  input  32  store data; rN_byteen  input  4  byte enables, 0000 = read.
REQ-006 SHALL have ports rN_gnt  output  1  transaction accepted this cycle (combinational).
REQ-007 SHALL have ports rN_rvalid  output  1  read/error response; rN_rdata  output  32  read word; rN_rerr  output  1  illegal byteen response.
REQ-008 SHALL have ports m_data_addr  output  32; m_data_wdata  output  32; m_data_byteen  output  4; m_data_rdata  input  32 (combinational read of addressed word; write commits at clk edge when byteen != 0).

Function
REQ-009 SHALL accept at most one transaction per cycle; gnt asserted only when the matching req is high.
REQ-010 SHALL drive m_data_* from the granted requester in the grant cycle, with m_data_addr = addr & 32'hFFFFFFFC.
REQ-011 SHALL drive m_data_addr = 0, m_data_wdata = 0, m_data_byteen = 0000 when nothing is granted.
REQ-012 SHALL treat legal byteen as 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111; any other value is granted but m_data_byteen forced 0000 and rN_rerr pulses for one cycle on the next cycle.
REQ-013 SHALL, for a granted legal read, register m_data_rdata at the grant edge and present it on rN_rdata with rN_rvalid = 1 exactly one cycle after grant; rvalid high for exactly one cycle.
REQ-014 SHALL not assert rvalid for writes; write latency is the grant edge.
REQ-015 SHALL hold rN_rdata at last value when rvalid is low.
REQ-016 SHALL implement FSM states NORMAL and BOOST; NORMAL: r0 wins when both request; BOOST: r1 wins when both request.
REQ-017 SHALL keep a wait counter (4 bits) incremented on each cycle r1_req = 1 and r1_gnt = 0, cleared when r1 is granted or r1_req = 0, saturating at 15.
REQ-018 SHALL transition NORMAL -> BOOST on the edge where the counter would reach MAX_WAIT; BOOST -> NORMAL on the edge where r1 is granted or r1_req = 0.
REQ-019 SHALL grant a sole requester immediately in either state.
REQ-020 SHALL require requesters to hold req, addr, wdata, byteen stable until gnt; the arbiter does not latch ungranted requests.

Reset
REQ-021 SHALL, while reset is high, force r0_gnt = r1_gnt = 0 and m_data_byteen = 0000 regardless of requests.
REQ-022 SHALL on reset set state NORMAL, wait counter 0, rvalid/rerr 0, rdata 0 for both ports.
REQ-023 SHALL drop any response pending at the reset edge (no rvalid after reset deasserts).

Structure
REQ-024 SHALL place the FSM state type, legal-byteen constants and MAX_WAIT default in shared package dm_arb_pkg.
REQ-025 SHALL implement byteen legality as sub-module byteen_check (4-bit in, 1-bit legal out), instantiated once per requester.

Verification
REQ-026 SHALL cover: r0 write addr 0x10 byteen 1111 data 0xDEADBEEF, then r0 read 0x13 -> r0_gnt both cycles, r0_rvalid next cycle with rdata 0xDEADBEEF.
REQ-027 SHALL cover: r1 sb addr 0x21 byteen 0010 data 0x0000AB00 on zeroed word, r1 read 0x20 -> rdata 0x0000AB00.
REQ-028 SHALL cover: r0 and r1 request continuously, MAX_WAIT=4 -> r0 granted 4 cycles, r1 granted cycle 5, then r0 again; repeating pattern.
REQ-029 SHALL cover: r0 byteen 0101 at 0x40 -> m_data_byteen 0000, r0_rerr pulses next cycle, memory word at 0x40 unchanged.
REQ-030 SHALL cover: reset asserted in the cycle after an r1 read grant -> no r1_rvalid, state NORMAL, counter 0 after reset.
REQ-031 SHALL cover: r1 alone requesting read 0x0 with r0 idle -> r1_gnt same cycle, r1_rvalid next cycle, counter stays 0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the arbiter FSM encoding and the legal byte-enable patterns.
package dm_arb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    BOOST  = 1'b1
  } arb_state_e;

  localparam int MAX_WAIT_DEFAULT = 4;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic be_is_read(
    input logic [3:0] be
  );
    return be == BE_NONE;
  endfunction

endpackage

// File: rtl/byteen_check.sv
// Flags whether a byte-enable pattern is a legal naturally
// aligned access (read, byte, halfword or word).
module byteen_check
  import dm_arb_pkg::*;
(
  input  logic [3:0] byteen,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    unique case (byteen)
      BE_NONE,
      BE_B0,
      BE_B1,
      BE_B2,
      BE_B3,
      BE_H0,
      BE_H1,
      BE_WORD: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter in front of the data memory port.
// r0 has priority; r1 is boosted after MAX_WAIT denials.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        r0_req,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_byteen,
  output logic        r0_gnt,
  output logic        r0_rvalid,
  output logic [31:0] r0_rdata,
  output logic        r0_rerr,

  input  logic        r1_req,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_byteen,
  output logic        r1_gnt,
  output logic        r1_rvalid,
  output logic [31:0] r1_rdata,
  output logic        r1_rerr,

  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e state_q;
  arb_state_e state_d;
  logic [3:0] wait_q;
  logic [3:0] wait_d;

  logic r0_legal;
  logic r1_legal;
  logic r0_rd;
  logic r1_rd;

  logic r0_rv_q;
  logic r1_rv_q;
  logic r0_err_q;
  logic r1_err_q;

  byteen_check u_be0 (
    .byteen (r0_byteen),
    .legal  (r0_legal)
  );

  byteen_check u_be1 (
    .byteen (r1_byteen),
    .legal  (r1_legal)
  );

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        r0_req && r1_req: begin
          if (state_q == BOOST) r1_gnt = 1'b1;
          else                  r0_gnt = 1'b1;
        end
        r0_req && !r1_req: r0_gnt = 1'b1;
        !r0_req && r1_req: r1_gnt = 1'b1;
        default: ;
      endcase
    end
  end

  // Illegal enables still consume the grant but never write.
  always_comb begin
    m_data_addr   = '0;
    m_data_wdata  = '0;
    m_data_byteen = BE_NONE;
    if (r0_gnt) begin
      m_data_addr   = r0_addr & WORD_MASK;
      m_data_wdata  = r0_wdata;
      m_data_byteen = r0_legal ? r0_byteen : BE_NONE;
    end else if (r1_gnt) begin
      m_data_addr   = r1_addr & WORD_MASK;
      m_data_wdata  = r1_wdata;
      m_data_byteen = r1_legal ? r1_byteen : BE_NONE;
    end
  end

  always_comb begin
    wait_d = '0;
    if (r1_req && !r1_gnt) begin
      wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL: begin
        if (r1_req && !r1_gnt && wait_d == MAX_WAIT_C) begin
          state_d = BOOST;
        end
      end
      BOOST: begin
        if (r1_gnt || !r1_req) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign r0_rd = r0_gnt && r0_legal && be_is_read(r0_byteen);
  assign r1_rd = r1_gnt && r1_legal && be_is_read(r1_byteen);

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_rv_q  <= 1'b0;
      r1_rv_q  <= 1'b0;
      r0_err_q <= 1'b0;
      r1_err_q <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_rv_q  <= r0_rd;
      r1_rv_q  <= r1_rd;
      r0_err_q <= r0_gnt && !r0_legal;
      r1_err_q <= r1_gnt && !r1_legal;
      if (r0_rd) r0_rdata <= m_data_rdata;
      if (r1_rd) r1_rdata <= m_data_rdata;
    end
  end

  // A response in flight when reset rises is dropped, not shown.
  assign r0_rvalid = r0_rv_q  && !reset;
  assign r1_rvalid = r1_rv_q  && !reset;
  assign r0_rerr   = r0_err_q && !reset;
  assign r1_rerr   = r1_err_q && !reset;

endmodule
